// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the serial shift-chain sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 4;

    localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    // Count register, holds at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_TOP)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: loads a word, shifts it MSB-first into the chain, flushes with zeros,
// reassembles the word from the chain tap and counts falling-edge pulses.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    output logic             ser_out,
    output logic             ser_en,
    input  logic             tap_in,
    input  logic             edge_in,
    output logic [WIDTH-1:0] rx_data,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int FW = $clog2(DEPTH);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] sreg_r;
    logic [BW-1:0]    bitcnt_r;
    logic [FW-1:0]    flcnt_r;
    logic [DEPTH-1:0] en_dly_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             accept_s;
    logic             edge_inc_s;

    assign accept_s   = (state_r == IDLE) && req_valid;
    assign edge_inc_s = ((state_r == SHIFT) || (state_r == FLUSH)) && edge_in;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = SHIFT;
                else          state_s = IDLE;
            end
            SHIFT: begin
                if (bitcnt_r == '0) state_s = FLUSH;
                else                state_s = SHIFT;
            end
            FLUSH: begin
                if (flcnt_r == '0) state_s = DONE;
                else               state_s = FLUSH;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Shift register and the bit/flush counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sreg_r   <= '0;
            bitcnt_r <= '0;
            flcnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sreg_r   <= req_data;
                        bitcnt_r <= BW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    sreg_r   <= {sreg_r[WIDTH-2:0], 1'b0};
                    bitcnt_r <= bitcnt_r - BW'(1);
                    if (bitcnt_r == '0) flcnt_r <= FW'(DEPTH - 1);
                end
                FLUSH: begin
                    if (flcnt_r != '0) flcnt_r <= flcnt_r - FW'(1);
                end
                default: begin
                    sreg_r <= sreg_r;
                end
            endcase
        end
    end

    // ser_en delayed by the chain latency marks which tap samples carry data bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_dly_r <= '0;
        end else begin
            en_dly_r <= {en_dly_r[DEPTH-2:0], ser_en};
        end
    end

    // Receive word assembly; the delay line is empty whenever a new word is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_data_r <= '0;
        end else if (accept_s) begin
            rx_data_r <= '0;
        end else if (en_dly_r[DEPTH-1]) begin
            rx_data_r <= {rx_data_r[WIDTH-2:0], tap_in};
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (accept_s),
        .inc   (edge_inc_s),
        .cnt   (edge_cnt)
    );

    assign req_ready = (state_r == IDLE);
    assign ser_en    = (state_r == SHIFT);
    assign ser_out   = (state_r == SHIFT) && sreg_r[WIDTH-1];
    assign busy      = (state_r != IDLE);
    assign done      = (state_r == DONE);
    assign rx_data   = rx_data_r;

endmodule
